cic_interpolator: RTL and testbench

- N-stage cascaded integrator-comb interpolator: upsamples a WIDTH-bit signed input stream by a runtime rate R (1..RMAX).
- Transmit-side counterpart of the cic_decimator: feeds the DAC/modulator path at the high sample rate.
- Structure: N comb stages at input rate, zero-stuff by R, N integrator stages at output rate.
- Valid/ready streaming on both sides, same conventions as cic_decimator.

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_comb_stage.sv | 49 ++++
 rtl/cic_interpolator.sv | 108 ++++++++++
 tb/tb_cic_interpolator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared sizing helpers for the CIC decimator/interpolator pair.
package cic_pkg;

  localparam int CIC_RMAX_DEFAULT = 4;
  localparam int CIC_RATE_W = $clog2(CIC_RMAX_DEFAULT + 1);

  function automatic int cic_rate_width(input int rmax);
    return $clog2(rmax + 1);
  endfunction

  // Bit growth is max(N, clog2((R*M)^N / R)) on top of the sample width.
  function automatic int cic_reg_width(input int width, input int rmax, input int m, input int n);
    int gain;
    int growth;
    gain = 1;
    for (int i = 0; i < n; i++) begin
      gain = gain * rmax * m;
    end
    growth = $clog2(gain / rmax);
    return width + ((n > growth) ? n : growth);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: y <= x - x[n-M], advancing only when en is high.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int REG_WIDTH = 18,
  parameter int M = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [REG_WIDTH-1:0] x,
  output logic [REG_WIDTH-1:0] y
);

  logic [REG_WIDTH-1:0] y_q, y_d;
  logic [REG_WIDTH-1:0] dly_q [M];
  logic [REG_WIDTH-1:0] dly_d [M];

  always_comb begin
    y_d = y_q;
    for (int i = 0; i < M; i++) begin
      dly_d[i] = dly_q[i];
    end
    if (en) begin
      y_d      = x - dly_q[M-1];
      dly_d[0] = x;
      for (int i = 1; i < M; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q <= '0;
      for (int i = 0; i < M; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      y_q <= y_d;
      for (int i = 0; i < M; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign y = y_q;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs at the input rate, zero-stuff by R,
// integrators at the output rate. Everything advances on an output transfer.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RMAX      = 4,
  parameter int M         = 1,
  parameter int N         = 2,
  parameter int REG_WIDTH = cic_reg_width(WIDTH, RMAX, M, N)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  input_tdata,
  input  logic                              input_tvalid,
  output logic                              input_tready,
  output logic [REG_WIDTH-1:0]              output_tdata,
  output logic                              output_tvalid,
  input  logic                              output_tready,
  input  logic [cic_rate_width(RMAX)-1:0]   rate
);

  localparam int RATE_W = cic_rate_width(RMAX);
  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(RMAX);

  logic [RATE_W-1:0]    rate_q, rate_d;
  logic [RATE_W-1:0]    cycle_q, cycle_d;
  logic [RATE_W-1:0]    rate_clamped, rate_eff;
  logic [REG_WIDTH-1:0] integ_q [N];
  logic [REG_WIDTH-1:0] integ_d [N];
  logic [REG_WIDTH-1:0] comb_x [N];
  logic [REG_WIDTH-1:0] comb_y [N];
  logic [REG_WIDTH-1:0] x_ext;
  logic                 cycle_zero, advance, comb_en;

  // Phase 0 is the only phase that consumes an input sample.
  assign cycle_zero    = (cycle_q == '0);
  assign input_tready  = rst && output_tready && cycle_zero;
  assign output_tvalid = rst && (input_tvalid || !cycle_zero);
  assign advance       = output_tvalid && output_tready;
  assign comb_en       = advance && cycle_zero;
  assign x_ext         = {{(REG_WIDTH-WIDTH){input_tdata[WIDTH-1]}}, input_tdata};
  assign output_tdata  = integ_q[N-1];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_comb
      if (gi == 0) begin : g_head
        assign comb_x[gi] = x_ext;
      end else begin : g_tail
        assign comb_x[gi] = comb_y[gi-1];
      end
      cic_comb_stage #(
        .REG_WIDTH(REG_WIDTH),
        .M        (M)
      ) u_stage (
        .clk(clk),
        .rst(rst),
        .en (comb_en),
        .x  (comb_x[gi]),
        .y  (comb_y[gi])
      );
    end
  endgenerate

  always_comb begin
    rate_clamped = rate;
    if (rate == '0) begin
      rate_clamped = RATE_ONE;
    end else if (rate > RATE_MAX) begin
      rate_clamped = RATE_MAX;
    end
    // A new rate is only picked up with an input sample, so bursts finish at the old rate.
    rate_eff = cycle_zero ? rate_clamped : rate_q;

    rate_d  = rate_q;
    cycle_d = cycle_q;
    for (int k = 0; k < N; k++) begin
      integ_d[k] = integ_q[k];
    end

    if (advance) begin
      rate_d     = rate_eff;
      cycle_d    = (cycle_q >= rate_eff - RATE_ONE) ? '0 : cycle_q + RATE_ONE;
      integ_d[0] = integ_q[0] + (cycle_zero ? comb_y[N-1] : '0);
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q  <= RATE_ONE;
      cycle_q <= '0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
      end
    end else begin
      rate_q  <= rate_d;
      cycle_q <= cycle_d;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator at default parameters (N=2, M=1, RMAX=4).
module tb_cic_interpolator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] input_tdata = '0;
  logic        input_tvalid = 1'b0;
  logic        input_tready;
  logic [17:0] output_tdata;
  logic        output_tvalid;
  logic        output_tready = 1'b0;
  logic [2:0]  rate = 3'd1;

  int tests_run = 0;
  int tests_failed = 0;

  // Rate-4 impulse response (1,2,3,4,3,2,1) as seen just before edge k.
  int exp4 [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 3, 2, 1, 0};
  // Impulse issued at rate 4, rate switched to 2 for the second input: triangle 1,2,1.
  int expmix [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0};

  always #5 clk = ~clk;

  cic_interpolator dut (
    .clk          (clk),
    .rst          (rst),
    .input_tdata  (input_tdata),
    .input_tvalid (input_tvalid),
    .input_tready (input_tready),
    .output_tdata (output_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready),
    .rate         (rate)
  );

  task automatic apply_reset();
    input_tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    input_tdata = 16'd5;
    rate = 3'd4;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (output_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tvalid got %b want 0", output_tvalid);
    end
    tests_run++;
    if (input_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tready got %b want 0", input_tready);
    end
    tests_run++;
    if (output_tdata !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_tdata got %0d want 0", $signed(output_tdata));
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (input_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_tready got %b want 1", input_tready);
    end
    $display("[TB] reset: checked held and released state");
    @(negedge clk);
  endtask

  task automatic test_dc_rate4();
    logic signed [17:0] exp_d;
    apply_reset();
    rate = 3'd4;
    input_tdata = 16'd1;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    exp_d = 18'sd4;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (k >= 13) begin
        tests_run++;
        if (output_tdata !== exp_d) begin
          tests_failed++;
          $display("FAIL dc4_data k=%0d got %0d want %0d", k, $signed(output_tdata), exp_d);
        end
      end
      tests_run++;
      if (input_tready !== ((k % 4) == 0)) begin
        tests_failed++;
        $display("FAIL dc4_tready k=%0d got %b want %b", k, input_tready, (k % 4) == 0);
      end
      $display("[TB] dc4 k=%0d tready=%b out=%0d", k, input_tready, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  task automatic test_dc_neg_rate2();
    logic signed [17:0] exp_d;
    apply_reset();
    rate = 3'd2;
    input_tdata = -16'sd100;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    exp_d = -18'sd200;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (k >= 7) begin
        tests_run++;
        if (output_tdata !== exp_d) begin
          tests_failed++;
          $display("FAIL dcneg_data k=%0d got %0d want %0d", k, $signed(output_tdata), exp_d);
        end
      end
      tests_run++;
      if (input_tready !== ((k % 2) == 0)) begin
        tests_failed++;
        $display("FAIL dcneg_tready k=%0d got %b want %b", k, input_tready, (k % 2) == 0);
      end
      $display("[TB] dcneg k=%0d tready=%b out=%0d", k, input_tready, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  task automatic test_rate1(input logic [2:0] r);
    logic signed [17:0] exp_d;
    apply_reset();
    rate = r;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      input_tdata = (k <= 9) ? 16'(k) : 16'd9;
      exp_d = (k >= 4) ? 18'(k - 4) : 18'sd0;
      #1;
      tests_run++;
      if (output_tdata !== exp_d) begin
        tests_failed++;
        $display("FAIL rate%0d_data k=%0d got %0d want %0d", r, k, $signed(output_tdata), exp_d);
      end
      tests_run++;
      if (input_tready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rate%0d_tready k=%0d got %b want 1", r, k, input_tready);
      end
      $display("[TB] rate%0d k=%0d in=%0d out=%0d", r, k, input_tdata, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic signed [17:0] exp_d;
    apply_reset();
    rate = 3'd4;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      input_tdata = (k == 0) ? 16'd1 : 16'd0;
      if (k == 11) begin
        output_tready = 1'b0;
        exp_d = 18'sd2;
        for (int s = 0; s < 5; s++) begin
          #1;
          tests_run++;
          if (output_tdata !== exp_d) begin
            tests_failed++;
            $display("FAIL stall_data s=%0d got %0d want %0d", s, $signed(output_tdata), exp_d);
          end
          tests_run++;
          if (input_tready !== 1'b0 || output_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hs s=%0d got tready=%b tvalid=%b want tready=0 tvalid=1",
                     s, input_tready, output_tvalid);
          end
          $display("[TB] stall s=%0d out=%0d", s, $signed(output_tdata));
          @(negedge clk);
        end
        output_tready = 1'b1;
      end
      exp_d = 18'(exp4[k]);
      #1;
      tests_run++;
      if (output_tdata !== exp_d) begin
        tests_failed++;
        $display("FAIL bp_data k=%0d got %0d want %0d", k, $signed(output_tdata), exp_d);
      end
      tests_run++;
      if (input_tready !== ((k % 4) == 0)) begin
        tests_failed++;
        $display("FAIL bp_tready k=%0d got %b want %b", k, input_tready, (k % 4) == 0);
      end
      $display("[TB] bp k=%0d tready=%b out=%0d", k, input_tready, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  task automatic test_rate_change();
    logic signed [17:0] exp_d;
    logic               exp_rdy;
    apply_reset();
    rate = 3'd4;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      input_tdata = (k == 0) ? 16'd1 : 16'd0;
      if (k == 2) rate = 3'd2;
      exp_d = 18'(expmix[k]);
      exp_rdy = (k < 4) ? (k == 0) : ((k % 2) == 0);
      #1;
      tests_run++;
      if (output_tdata !== exp_d) begin
        tests_failed++;
        $display("FAIL ratechg_data k=%0d got %0d want %0d", k, $signed(output_tdata), exp_d);
      end
      tests_run++;
      if (input_tready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL ratechg_tready k=%0d got %b want %b", k, input_tready, exp_rdy);
      end
      $display("[TB] ratechg k=%0d tready=%b out=%0d", k, input_tready, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic signed [17:0] exp_d;
    apply_reset();
    rate = 3'd4;
    input_tvalid = 1'b1;
    output_tready = 1'b1;
    // Run the impulse up to its peak; the phase counter then sits at 1.
    for (int k = 0; k < 13; k++) begin
      input_tdata = (k == 0) ? 16'd1 : 16'd0;
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (output_tdata !== 18'd4 || output_tvalid !== 1'b1 || input_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL prereset got data=%0d tvalid=%b tready=%b want data=4 tvalid=1 tready=0",
               $signed(output_tdata), output_tvalid, input_tready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (output_tdata !== 18'd0 || output_tvalid !== 1'b0 || input_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset got data=%0d tvalid=%b tready=%b want 0 0 0",
               $signed(output_tdata), output_tvalid, input_tready);
    end
    $display("[TB] midreset asserted out=%0d", $signed(output_tdata));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 18; k++) begin
      input_tdata = (k == 0) ? 16'd1 : 16'd0;
      exp_d = 18'(exp4[k]);
      #1;
      tests_run++;
      if (output_tdata !== exp_d) begin
        tests_failed++;
        $display("FAIL fresh_data k=%0d got %0d want %0d", k, $signed(output_tdata), exp_d);
      end
      tests_run++;
      if (input_tready !== ((k % 4) == 0)) begin
        tests_failed++;
        $display("FAIL fresh_tready k=%0d got %b want %b", k, input_tready, (k % 4) == 0);
      end
      $display("[TB] fresh k=%0d tready=%b out=%0d", k, input_tready, $signed(output_tdata));
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dc_rate4();
    test_dc_neg_rate2();
    test_rate1(3'd1);
    test_rate1(3'd0);
    test_backpressure();
    test_rate_change();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
